// File: rtl/pc_unit.sv
// Program-counter unit for the NES CPU fetch stage.
// Handles variable-length increment, absolute jumps, signed relative
// branches with a page-cross fix-up cycle, and reset/NMI/IRQ vector fetch
// through the shared data-memory read port.
//
// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | normal operation; PC advances by increment/jump/branch
// VEC_LO | reading vector low byte from base address
// VEC_HI | reading vector high byte from base+1, then load PC
// BR_FIX | second cycle of a page-crossing branch; high byte corrected
module pc_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int PAGE_W = 8,
    parameter int INC_W  = 2,
    parameter logic [ADDR_W-1:0] RESET_VEC = 16'hFFFC,
    parameter logic [ADDR_W-1:0] NMI_VEC   = 16'hFFFA,
    parameter logic [ADDR_W-1:0] IRQ_VEC   = 16'hFFFE
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              stall_i,
    input  logic [INC_W-1:0]  inc_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              branch_i,
    input  logic [PAGE_W-1:0] branch_off_i,
    input  logic              vec_req_i,
    input  logic [1:0]        vec_sel_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              busy_o,
    output logic              page_cross_o
);

    typedef enum logic [1:0] {RUN, VEC_LO, VEC_HI, BR_FIX} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   tgt_q, tgt_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic [ADDR_W-1:0]   br_target;
    logic [ADDR_W-1:0]   inc_sum;
    logic                same_page;
    logic [ADDR_W-1:0]   sel_vec;

    // Branch target, page comparison and increment sum for the RUN state.
    always_comb begin
        br_target = pc_q + {{(ADDR_W-PAGE_W){branch_off_i[PAGE_W-1]}}, branch_off_i};
        inc_sum   = pc_q + {{(ADDR_W-INC_W){1'b0}}, inc_i};
        same_page = (br_target[ADDR_W-1:PAGE_W] == pc_q[ADDR_W-1:PAGE_W]);
        case (vec_sel_i)
            2'd0:    sel_vec = RESET_VEC;
            2'd1:    sel_vec = NMI_VEC;
            default: sel_vec = IRQ_VEC;
        endcase
    end

    // Next-state and datapath selection; priority vec_req > jump > branch > inc.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        base_d  = base_q;
        tgt_d   = tgt_q;
        lo_d    = lo_q;
        case (state_q)
            RUN: begin
                if (!stall_i) begin
                    if (vec_req_i) begin
                        base_d  = sel_vec;
                        state_d = VEC_LO;
                    end else if (jump_i) begin
                        pc_d = jump_addr_i;
                    end else if (branch_i) begin
                        if (same_page) begin
                            pc_d = br_target;
                        end else begin
                            // Stale high byte this cycle, corrected in BR_FIX.
                            pc_d    = {pc_q[ADDR_W-1:PAGE_W], br_target[PAGE_W-1:0]};
                            tgt_d   = br_target;
                            state_d = BR_FIX;
                        end
                    end else begin
                        pc_d = inc_sum;
                    end
                end
            end
            VEC_LO: begin
                if (mem_rvalid_i) begin
                    lo_d    = mem_rdata_i;
                    state_d = VEC_HI;
                end
            end
            VEC_HI: begin
                if (mem_rvalid_i) begin
                    pc_d    = {mem_rdata_i, lo_q};
                    state_d = RUN;
                end
            end
            BR_FIX: begin
                pc_d    = tgt_q;
                state_d = RUN;
            end
            default: state_d = VEC_LO;
        endcase
    end

    // State and datapath registers; reset always starts a reset-vector fetch.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= VEC_LO;
            pc_q    <= '0;
            base_q  <= RESET_VEC;
            tgt_q   <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            base_q  <= base_d;
            tgt_q   <= tgt_d;
            lo_q    <= lo_d;
        end
    end

    // Status and memory-port outputs decoded from registered state only.
    always_comb begin
        pc_o         = pc_q;
        pc_valid_o   = (state_q == RUN);
        busy_o       = (state_q != RUN);
        page_cross_o = (state_q == BR_FIX);
        mem_req_o    = (state_q == VEC_LO) || (state_q == VEC_HI);
        mem_addr_o   = (state_q == VEC_HI) ? (base_q + ADDR_W'(1)) : base_q;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the NES CPU, the successor of the plain increment/branch PC register. It adds variable instruction-length increment, absolute jumps, signed relative branches with a 6502-style page-cross fix-up cycle, and a vector-fetch state machine. The vector fetch loads the PC from memory on reset, NMI and IRQ/BRK. It sits in the fetch stage, driven by the control unit, and shares the data-memory read port during vector fetch.

## Interface
- ADDR_W, 16, PC width; must equal 2*DATA_W
- DATA_W, 8, memory data width
- PAGE_W, 8, page-offset bits; also the width of branch_off_i
- INC_W, 2, width of inc_i
- RESET_VEC, 16'hFFFC, reset vector address (low byte; high byte at +1)
- NMI_VEC, 16'hFFFA, NMI vector address
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector address

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rstn_i  in  1  asynchronous, active-low reset
- stall_i  in  1  hold PC in RUN state
- inc_i  in  INC_W  unsigned increment (instruction length, 0..3)
- jump_i  in  1  load jump_addr_i
- jump_addr_i  in  ADDR_W  absolute target
- branch_i  in  1  taken relative branch
- branch_off_i  in  PAGE_W  signed two's-complement offset
- vec_req_i  in  1  start vector fetch
- vec_sel_i  in  2  0 = RESET_VEC, 1 = NMI_VEC, 2/3 = IRQ_VEC
- mem_req_o  out  1  vector read request
- mem_addr_o  out  ADDR_W  vector read address
- mem_rdata_i  in  DATA_W  read data
- mem_rvalid_i  in  1  read data valid
- pc_o  out  ADDR_W  current PC (registered)
- pc_valid_o  out  1  high only in RUN state
- busy_o  out  1  high in VEC_LO, VEC_HI, BR_FIX
- page_cross_o  out  1  high during the BR_FIX cycle

## Operation
- States: RUN, VEC_LO, VEC_HI, BR_FIX.
- Reset (any state, asynchronous):
  - state = VEC_LO, vector base = RESET_VEC, pc_o = 0, lo-byte register = 0.
  - pc_valid_o = 0, busy_o = 1, page_cross_o = 0.
  - mem_req_o = 1, mem_addr_o = RESET_VEC.
- RUN with stall_i = 1: PC and state hold; all requests, including vec_req_i, are ignored. Requesters hold their request until it is accepted.
- RUN with stall_i = 0, priority is vec_req_i > jump_i > branch_i > increment:
  - vec_req_i: latch the vector base from vec_sel_i; go to VEC_LO; pc_o holds.
  - jump_i: pc_o <= jump_addr_i.
  - branch_i: target = pc_o + sign_extend(branch_off_i), mod 2^ADDR_W.
    - If target[ADDR_W-1:PAGE_W] equals pc_o[ADDR_W-1:PAGE_W]: pc_o <= target.
    - Otherwise: pc_o <= {pc_o[ADDR_W-1:PAGE_W], target[PAGE_W-1:0]}, latch target, go to BR_FIX.
  - none of the above: pc_o <= pc_o + inc_i, zero-extended, wraps mod 2^ADDR_W. inc_i = 0 holds the PC.
- BR_FIX: pc_o <= latched target; return to RUN. All inputs, including stall_i, are ignored.
- VEC_LO:
  - mem_req_o = 1, mem_addr_o = base.
  - On mem_rvalid_i, capture mem_rdata_i as the low byte and go to VEC_HI.
- VEC_HI:
  - mem_req_o = 1, mem_addr_o = base + 1.
  - On mem_rvalid_i, pc_o <= {mem_rdata_i, low byte} and go to RUN.
- In both VEC states, stall_i, jump_i, branch_i and vec_req_i are ignored. A new vec_req_i is never queued.
- mem_req_o is 0 in RUN and BR_FIX.

## Timing
- Increment, jump and in-page branch: pc_o updates on the edge where the request is sampled, i.e. 1-cycle latency.
- Page-crossing branch: 2 cycles.
  - Edge 1: pc_o shows the stale high byte and new low byte; page_cross_o = 1 and busy_o = 1 for the next cycle.
  - Edge 2: pc_o = target.
- Vector fetch: minimum 3 cycles from vec_req_i to pc_valid_o = 1 (accept, VEC_LO, VEC_HI), each VEC state waits for mem_rvalid_i.
- The memory may return mem_rvalid_i in the same cycle mem_req_o rises. Any rvalid seen in RUN or BR_FIX is ignored.
- After reset release, a fetch needs 2 rvalid beats before pc_valid_o rises.
- pc_valid_o and busy_o are decoded from registered state, so they are glitch-free.

## Test plan
- Reset vector: release rstn_i; memory at FFFC = 34, FFFD = 12 with rvalid the same cycle -> mem_addr_o FFFC then FFFD; pc_o = 1234 and pc_valid_o = 1 two cycles after release.
- Increment and wrap: pc_o = FFFE, inc_i = 3 -> pc_o = 0001. inc_i = 0 -> pc_o holds. stall_i = 1 with inc_i = 2 -> pc_o holds.
- In-page branch: pc_o = 1210, offset 8'hF0 -> pc_o = 1200 next cycle; busy_o stays 0; page_cross_o stays 0.
- Page-cross branch: pc_o = 12F0, offset 8'h20 -> pc_o = 1210 with page_cross_o = 1, then pc_o = 1310. Backward case: pc_o = 1205, offset 8'hF0 -> 12F5, then 11F5.
- Priority: vec_req_i (sel = 1), jump_i and branch_i asserted in the same cycle -> NMI fetch at FFFA/FFFB; the jump is discarded. jump_i with branch_i -> pc_o = jump_addr_i.
- Delayed memory and mid-fetch reset: rvalid delayed 3 cycles -> pc_o holds and mem_addr_o is stable while waiting. Assert rstn_i in VEC_HI of an IRQ fetch -> state returns to VEC_LO with mem_addr_o = FFFC and pc_o = 0.
